// File: rtl/rv64m_mul_sequencer.sv
// ---------------------------------------------------------------------------
// rv64m_mul_sequencer
//
// Iterative RV64M multiply unit. One op is accepted over a valid/ready
// handshake. The unit multiplies the operand magnitudes with a shift-add
// datapath that retires BITS_PER_CYCLE multiplier bits per cycle, applies the
// sign correction, and returns the architecturally selected XLEN-bit result
// together with the full 2*XLEN-bit product.
//
// Parameters:
//   XLEN            operand width (even, >= 32 for MULW support)
//   BITS_PER_CYCLE  multiplier bits retired per CALC cycle (1, 2 or 4),
//                   must divide XLEN
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   flush        aborts any in-flight op, takes priority over handshakes
//   in_valid     op and operands valid
//   in_ready     unit can accept an op (IDLE, not in reset, no flush)
//   in_op        funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_word      1 = MULW
//   in_rs1       operand A
//   in_rs2       operand B
//   out_valid    result valid (DONE state)
//   out_ready    consumer accepts the result
//   out_result   selected XLEN-bit result
//   out_product  sign-corrected full 2*XLEN-bit product
//   busy         an op is in flight
// ---------------------------------------------------------------------------
module rv64m_mul_sequencer #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic                in_word,
  input  logic [XLEN-1:0]     in_rs1,
  input  logic [XLEN-1:0]     in_rs2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [2*XLEN-1:0]   out_product,
  output logic                busy
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam int SH_W  = $clog2(2 * XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic [XLEN-1:0]    mag_a;
  logic [XLEN-1:0]    mplier;
  logic [2*XLEN-1:0]  acc;
  logic               neg;
  logic [1:0]         op;
  logic               word;

  // Handshake and status outputs are gated by reset and flush so that the
  // issue logic never sees the unit as ready while it is being cleared.
  assign in_ready = rst_n && !flush && (state == IDLE);
  assign busy     = rst_n && (state != IDLE);

  // ---------------------------------------------------------------------
  // Operand preparation for the op currently presented on the input.
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] opnd_a, opnd_b;
  logic            a_signed, b_signed;
  logic            sign_a, sign_b;

  // NOTE: every signal driven in this always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    opnd_a   = in_rs1;
    opnd_b   = in_rs2;
    a_signed = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    b_signed = (in_op == OP_MULH);
    if (in_word) begin
      // MULW: sign-extended low words, multiplied as MUL. Only the low 32
      // product bits are architecturally visible, so signedness is moot.
      opnd_a   = {{(XLEN-32){in_rs1[31]}}, in_rs1[31:0]};
      opnd_b   = {{(XLEN-32){in_rs2[31]}}, in_rs2[31:0]};
      a_signed = 1'b0;
      b_signed = 1'b0;
    end
    sign_a = a_signed && opnd_a[XLEN-1];
    sign_b = b_signed && opnd_b[XLEN-1];
  end

  // Magnitudes: the most-negative value negates to itself, which read as an
  // unsigned XLEN-bit number is exactly 2^(XLEN-1), the correct magnitude.
  logic [XLEN-1:0] abs_a, abs_b;
  assign abs_a = sign_a ? (~opnd_a + 1'b1) : opnd_a;
  assign abs_b = sign_b ? (~opnd_b + 1'b1) : opnd_b;

  // ---------------------------------------------------------------------
  // One shift-add step: |A| times the current multiplier digit, placed at
  // the bit weight of that digit.
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] digit_ext;
  logic [2*XLEN-1:0] partial;
  logic [2*XLEN-1:0] addend;
  logic [SH_W-1:0]   shamt;

  assign digit_ext = {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
  assign partial   = {{XLEN{1'b0}}, mag_a} * digit_ext;
  assign shamt     = SH_W'(counter) * SH_W'(BITS_PER_CYCLE);
  assign addend    = partial << shamt;

  // ---------------------------------------------------------------------
  // Sign correction and architectural result select.
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] fixed;
  logic [XLEN-1:0]   result_sel;

  assign fixed = neg ? (~acc + 1'b1) : acc;

  always_comb begin
    result_sel = fixed[2*XLEN-1:XLEN];
    if (word) begin
      result_sel = {{(XLEN-32){fixed[31]}}, fixed[31:0]};
    end else if (op == OP_MUL) begin
      result_sel = fixed[XLEN-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM and datapath registers.
  // ---------------------------------------------------------------------
  // NOTE: mag_a, mplier, acc, neg, op and word are not reset. Each is loaded
  // on acceptance before it is ever read, so clearing them buys nothing.
  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      counter     <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_product <= '0;
    end else if (flush) begin
      state     <= IDLE;
      counter   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_a   <= abs_a;
            mplier  <= abs_b;
            neg     <= sign_a ^ sign_b;
            op      <= in_word ? OP_MUL : in_op;
            word    <= in_word;
            acc     <= '0;
            counter <= '0;
            state   <= CALC;
          end
        end

        CALC: begin
          // Counter reaching N marks the accumulator complete; that cycle
          // performs no arithmetic and only advances to FIX.
          if (counter == CNT_W'(N)) begin
            state <= FIX;
          end else begin
            acc     <= acc + addend;
            mplier  <= mplier >> BITS_PER_CYCLE;
            counter <= counter + 1'b1;
          end
        end

        FIX: begin
          out_product <= fixed;
          out_result  <= result_sel;
          out_valid   <= 1'b1;
          state       <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            counter   <= '0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv64m_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rv64m_mul_sequencer
//
// Three instances of the multiplier (BITS_PER_CYCLE = 1, 2, 4) share one
// stimulus stream. Expected results come from a reference model using plain
// 128-bit arithmetic on sign- or zero-extended operands.
// ---------------------------------------------------------------------------
module tb_rv64m_mul_sequencer;

  localparam int XLEN = 64;
  localparam int NC   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                flush;
  logic                in_valid;
  logic [1:0]          in_op;
  logic                in_word;
  logic [XLEN-1:0]     in_rs1;
  logic [XLEN-1:0]     in_rs2;
  logic                out_ready;
  logic [NC-1:0]       in_ready;
  logic [NC-1:0]       out_valid;
  logic [NC-1:0]       busy;
  logic [XLEN-1:0]     out_result  [NC];
  logic [2*XLEN-1:0]   out_product [NC];

  // out_valid first rises N+2 edges after the accepting edge.
  int lat [NC] = '{66, 34, 18};

  for (genvar g = 0; g < NC; g++) begin : g_dut
    rv64m_mul_sequencer #(
      .XLEN(XLEN),
      .BITS_PER_CYCLE(1 << g)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready[g]),
      .in_op(in_op),
      .in_word(in_word),
      .in_rs1(in_rs1),
      .in_rs2(in_rs2),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .out_result(out_result[g]),
      .out_product(out_product[g]),
      .busy(busy[g])
    );
  end

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0]   last_res;
  logic [2*XLEN-1:0] last_prod;

  task automatic check(input string tag, input logic [2*XLEN-1:0] got,
                       input logic [2*XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: extend each operand to 128 bits according to its signedness
  // and take the 128-bit product.
  task automatic ref_model(input logic [1:0] op, input logic w,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           output logic [2*XLEN-1:0] prod,
                           output logic [XLEN-1:0] res);
    logic [XLEN-1:0]   aa, bb;
    logic [2*XLEN-1:0] ea, eb;
    bit                sa, sb;
    aa = a;
    bb = b;
    sa = (op == 2'b01) || (op == 2'b10);
    sb = (op == 2'b01);
    if (w) begin
      aa = {{32{a[31]}}, a[31:0]};
      bb = {{32{b[31]}}, b[31:0]};
      sa = 0;
      sb = 0;
    end
    ea = sa ? {{XLEN{aa[XLEN-1]}}, aa} : {{XLEN{1'b0}}, aa};
    eb = sb ? {{XLEN{bb[XLEN-1]}}, bb} : {{XLEN{1'b0}}, bb};
    prod = ea * eb;
    if (w)             res = {{32{prod[31]}}, prod[31:0]};
    else if (op == 0)  res = prod[XLEN-1:0];
    else               res = prod[2*XLEN-1:XLEN];
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Issue one op to all instances with out_ready high and check each result,
  // its full product and its latency.
  task automatic run_op(input logic [1:0] op, input logic w,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ep;
    logic [XLEN-1:0]   er;
    logic [NC-1:0]     done;
    int                k;
    ref_model(op, w, a, b, ep, er);
    in_op = op; in_word = w; in_rs1 = a; in_rs2 = b;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("in_ready_idle", in_ready, {NC{1'b1}});
    step();
    in_valid = 1'b0;
    in_op = 2'($urandom); in_word = 1'($urandom);
    in_rs1 = rnd64(); in_rs2 = rnd64();
    done = '0;
    k = 0;
    while (done != {NC{1'b1}} && k < 200) begin
      step();
      k++;
      for (int g = 0; g < NC; g++) begin
        if (!done[g] && out_valid[g]) begin
          check("latency", k, lat[g]);
          check("result", out_result[g], er);
          check("product", out_product[g], ep);
          if (g == 1) begin
            last_res  = out_result[g];
            last_prod = out_product[g];
          end
          done[g] = 1'b1;
        end
      end
    end
    check("op_timeout", done, {NC{1'b1}});
    step();
    check("busy_after", busy, '0);
  endtask

  // Watch for any out_valid over a window; none expected.
  task automatic expect_quiet(input string tag, input int cycles);
    logic [NC-1:0] seen;
    seen = '0;
    for (int i = 0; i < cycles; i++) begin
      step();
      seen |= out_valid;
    end
    check(tag, seen, '0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*XLEN-1:0] ep;
    logic [XLEN-1:0]   er;
    int                k;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_word = 1'b0; in_rs1 = '0; in_rs2 = '0;
    @(negedge clk);
    #1;
    check("rst_busy", busy, '0);
    check("rst_in_ready", in_ready, '0);
    step();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, '0);
    check("rst_result", out_result[1], '0);
    check("rst_product", out_product[1], '0);
    check("rst_in_ready_after", in_ready, {NC{1'b1}});

    // Directed ops
    run_op(2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
    check("t1_mul", last_res, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'b11, 1'b0, '1, '1);
    check("t2_mulhu", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t2_mulhu_lo", last_prod[63:0], 64'h1);
    run_op(2'b01, 1'b0, '1, '1);
    check("t2_mulh", last_res, 64'h0);
    run_op(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    check("t3_mulh_min", last_res, 64'h4000_0000_0000_0000);
    run_op(2'b10, 1'b0, '1, '1);
    check("t3_mulhsu", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(2'b00, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2);
    check("t4_mulw", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(2'b11, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2);
    check("t4_mulw_op11", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(2'b00, 1'b0, 64'd0, rnd64());
    check("zero_operand", last_res, 64'h0);

    // Backpressure on the result port
    in_op = 2'b00; in_word = 1'b0; in_rs1 = rnd64(); in_rs2 = rnd64();
    ref_model(in_op, in_word, in_rs1, in_rs2, ep, er);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid[1] && k < 100) begin
      step();
      k++;
    end
    check("bp_latency", k, 34);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_op = 2'($urandom); in_rs1 = rnd64(); in_rs2 = rnd64();
      #1;
      check("bp_in_ready", in_ready[1], 1'b0);
      check("bp_valid_held", out_valid[1], 1'b1);
      check("bp_result_held", out_result[1], er);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_valid_drop", out_valid[1], 1'b0);
    check("bp_in_ready_after", in_ready[1], 1'b1);
    k = 0;
    while (busy != '0 && k < 100) begin
      step();
      k++;
    end
    check("bp_drain", busy, '0);

    // Flush mid-CALC
    in_op = 2'b01; in_word = 1'b0; in_rs1 = rnd64(); in_rs2 = rnd64();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, '0);
    step();
    flush = 1'b0;
    check("flush_idle", busy, '0);
    check("flush_no_valid", out_valid, '0);
    expect_quiet("flush_quiet", 80);

    // Flush together with in_valid in IDLE: op not accepted
    in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_idle_ready", in_ready, '0);
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_reject", busy, '0);

    // Reset during FIX of the BITS_PER_CYCLE=2 instance
    in_op = 2'b00; in_rs1 = rnd64(); in_rs2 = rnd64();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 33; i++) step();
    check("fix_no_valid_yet", out_valid[1], 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, '0);
    check("rst_mid_ready", in_ready, '0);
    step();
    check("rst_mid_valid", out_valid, '0);
    check("rst_mid_result", out_result[1], '0);
    check("rst_mid_product", out_product[1], '0);
    rst_n = 1'b1;
    expect_quiet("rst_quiet", 80);

    // Random sweep with corner-biased operands
    for (int i = 0; i < 1000; i++) begin
      logic [XLEN-1:0] a, b;
      a = rnd64();
      b = rnd64();
      case ($urandom_range(0, 7))
        0: a = 64'h8000_0000_0000_0000;
        1: b = '1;
        2: a = '0;
        3: b = 64'h8000_0000_0000_0000;
        default: ;
      endcase
      run_op(2'($urandom), ($urandom_range(0, 3) == 0), a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
